// File: rtl/abl_pkg.sv
// abl_pkg: shared definitions for the 6502 low-byte address stage.
// Holds the 5-bit address-mode op encoding that the high-byte stage
// decodes identically, and a decode helper for the PC-load state set.
package abl_pkg;

  typedef enum logic [4:0] {
    AB_FETCH = 5'd0,
    AB_DATA  = 5'd1,
    AB_JSR0  = 5'd2,
    AB_JSR1  = 5'd3,
    AB_IND0  = 5'd4,
    AB_TXS   = 5'd5,
    AB_IRQ0  = 5'd6,
    AB_ZPXY  = 5'd7,
    AB_INDX0 = 5'd8,
    AB_INDX1 = 5'd9,
    AB_ABS0  = 5'd10,
    AB_JMP0  = 5'd11,
    AB_RTS0  = 5'd12,
    AB_RTS1  = 5'd13,
    AB_BRA0  = 5'd14,
    AB_PLA   = 5'd15,
    AB_PHA   = 5'd16,
    AB_BRK   = 5'd17,
    AB_BRK1  = 5'd18,
    AB_BRK2  = 5'd19,
    AB_RST   = 5'd20,
    AB_NMI   = 5'd21,
    AB_RMW   = 5'd22
  } ab_op_e;

  // States in which the PC advances to ABL+1.
  function automatic logic is_load_pc(input logic [4:0] op);
    return (op == AB_ZPXY) || (op == AB_BRK)  || (op == AB_ABS0) ||
           (op == AB_TXS)  || (op == AB_FETCH) || (op == AB_IND0);
  endfunction

endpackage

// File: rtl/abl_sp.sv
// abl_sp: 8-bit stack pointer register.
// Ports: clk, rst (sync, active high), en (advance), inc/dec/ld controls,
//   ld_val (TXS source), s_o (current S), s_inc_o (S+1, combinational).
// Load has priority over inc, inc over dec; all arithmetic wraps mod 256.
module abl_sp #(
  parameter logic [7:0] RESET_SP = 8'hFD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  input  logic       dec,
  input  logic       ld,
  input  logic [7:0] ld_val,
  output logic [7:0] s_o,
  output logic [7:0] s_inc_o
);

  logic [7:0] s_q, s_d;

  assign s_inc_o = s_q + 8'd1;
  assign s_o     = s_q;

  always_comb begin
    s_d = s_q;
    if (ld)       s_d = ld_val;
    else if (inc) s_d = s_inc_o;
    else if (dec) s_d = s_q - 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst)     s_q <= RESET_SP;
    else if (en) s_q <= s_d;
  end

endmodule

// File: rtl/abl.sv
// abl: low-byte address generator for the CPLD 6502.
// Ports:
//   clk, rst (sync, active high), RDY (advance enable)
//   op      address-mode state (abl_pkg::ab_op_e encoding)
//   DB, SB  data bus and special bus; use_idx adds SB as an index
//   ABL     address bus low byte
//   CO      registered carry of the last ABL add (high-byte CI)
//   PCL8    PCL increment wraps FF->00 this cycle (combinational)
//   PCL_OUT current PCL; PCL_OE requests PCL onto DB for pushes
module abl
  import abl_pkg::*;
#(
  parameter logic [7:0] RESET_SP = 8'hFD,
  parameter logic [7:0] VEC_NMI  = 8'hFA,
  parameter logic [7:0] VEC_RST  = 8'hFC,
  parameter logic [7:0] VEC_IRQ  = 8'hFE
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RDY,
  input  logic [4:0] op,
  input  logic [7:0] DB,
  input  logic [7:0] SB,
  input  logic       use_idx,
  output logic [7:0] ABL,
  output logic       CO,
  output logic       PCL8,
  output logic [7:0] PCL_OUT,
  output logic       PCL_OE
);

  logic [7:0] abl_q, abl_d;
  logic [7:0] pcl_q, pcl_d;
  logic [7:0] dl_q;
  logic       co_q, co_d;
  logic       load_pc;
  logic [7:0] abl_inc, idx;
  logic [8:0] sum_db, sum_bra;
  logic [7:0] sp_w, sp_inc_w;
  logic       sp_inc, sp_dec, sp_ld;

  assign load_pc = is_load_pc(op);
  assign abl_inc = abl_q + 8'd1;
  assign pcl_d   = load_pc ? abl_inc : pcl_q;
  assign idx     = use_idx ? SB : 8'h00;
  assign sum_db  = {1'b0, DB} + {1'b0, idx};
  // Unsigned add only; SB sign extension is applied by the high-byte stage.
  assign sum_bra = {1'b0, pcl_q} + {1'b0, SB};

  assign PCL8    = load_pc && (abl_q == 8'hFF);
  assign ABL     = abl_q;
  assign CO      = co_q;
  assign PCL_OUT = pcl_q;
  assign PCL_OE  = (op == AB_JSR1) || (op == AB_BRK1);

  always_comb begin
    abl_d  = 8'h00;
    co_d   = 1'b0;
    sp_inc = 1'b0;
    sp_dec = 1'b0;
    sp_ld  = 1'b0;
    case (op)
      AB_FETCH, AB_DATA, AB_JSR1, AB_IND0, AB_IRQ0: abl_d = pcl_d;
      AB_TXS: begin
        abl_d = pcl_d;
        sp_ld = 1'b1;
      end
      AB_ZPXY, AB_INDX0: abl_d = sum_db[7:0];
      AB_ABS0: begin
        abl_d = sum_db[7:0];
        co_d  = sum_db[8];
      end
      // Pointer high byte fetch stays in zero page: no carry out.
      AB_INDX1: abl_d = abl_inc;
      AB_JMP0:  abl_d = dl_q;
      AB_RTS1: begin
        abl_d = dl_q + 8'd1;
        co_d  = (dl_q == 8'hFF);
      end
      AB_BRA0: begin
        abl_d = sum_bra[7:0];
        co_d  = sum_bra[8];
      end
      AB_PLA, AB_RTS0: begin
        abl_d  = sp_inc_w;
        sp_inc = 1'b1;
      end
      AB_PHA, AB_BRK, AB_BRK1, AB_JSR0: begin
        abl_d  = sp_w;
        sp_dec = 1'b1;
      end
      AB_RST:  abl_d = VEC_RST;
      AB_NMI:  abl_d = VEC_NMI;
      AB_BRK2: abl_d = VEC_IRQ;
      AB_RMW: begin
        abl_d = abl_q;
        co_d  = co_q;
      end
      default: ;
    endcase
  end

  abl_sp #(.RESET_SP(RESET_SP)) u_sp (
    .clk     (clk),
    .rst     (rst),
    .en      (RDY),
    .inc     (sp_inc),
    .dec     (sp_dec),
    .ld      (sp_ld),
    .ld_val  (SB),
    .s_o     (sp_w),
    .s_inc_o (sp_inc_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      abl_q <= VEC_RST;
      pcl_q <= VEC_RST;
      co_q  <= 1'b0;
      dl_q  <= 8'h00;
    end else if (RDY) begin
      abl_q <= abl_d;
      pcl_q <= pcl_d;
      co_q  <= co_d;
      dl_q  <= DB;
    end
  end

endmodule

// File: tb/tb_abl.sv
// tb_abl: scoreboard bench for abl. Stimulus pushes hand-computed expected
// values tagged with the cycle they are due; a monitor on the falling edge
// pops and compares each due entry.
module tb_abl;
  import abl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, RDY, use_idx;
  logic [4:0] op;
  logic [7:0] DB, SB;
  logic [7:0] ABL, PCL_OUT;
  logic       CO, PCL8, PCL_OE;

  abl dut (
    .clk(clk), .rst(rst), .RDY(RDY), .op(op), .DB(DB), .SB(SB),
    .use_idx(use_idx), .ABL(ABL), .CO(CO), .PCL8(PCL8),
    .PCL_OUT(PCL_OUT), .PCL_OE(PCL_OE)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    int         sel;
    logic [7:0] v;
    string      nm;
  } exp_t;

  localparam int S_ABL = 0, S_CO = 1, S_PCL8 = 2, S_PCL = 3, S_S = 4, S_OE = 5;

  exp_t q[$];
  int   cyc = 0;
  int   n_run = 0, n_fail = 0;
  bit   done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic drive(input logic r, input logic rdy, input logic [4:0] o,
                       input logic [7:0] db, input logic [7:0] sb, input logic ix);
    rst = r; RDY = rdy; op = o; DB = db; SB = sb; use_idx = ix;
  endtask

  // lag 0: check before the coming edge; lag 1: check after it.
  task automatic ex(input int lag, input int sel, input logic [7:0] v, input string nm);
    exp_t e;
    e.due = cyc + lag; e.sel = sel; e.v = v; e.nm = nm;
    q.push_back(e);
  endtask

  function automatic logic [7:0] actual(input int sel);
    case (sel)
      S_ABL:   return ABL;
      S_CO:    return {7'b0, CO};
      S_PCL8:  return {7'b0, PCL8};
      S_PCL:   return PCL_OUT;
      S_S:     return dut.sp_w;
      default: return {7'b0, PCL_OE};
    endcase
  endfunction

  // Monitor
  initial begin
    exp_t e;
    logic [7:0] a;
    while (!done || q.size() > 0) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        a = actual(e.sel);
        n_run++;
        if (a !== e.v) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h (cycle %0d)", e.nm, a, e.v, cyc);
        end
      end
    end
  end

  task automatic nxt;
    @(posedge clk); #1;
  endtask

  initial begin
    // reset with RDY high
    drive(1, 1, AB_FETCH, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'hFC, "rst_abl"); ex(1, S_S, 8'hFD, "rst_s");
    ex(1, S_CO, 8'h00, "rst_co");   ex(1, S_PCL, 8'hFC, "rst_pcl");
    nxt; drive(0, 1, AB_FETCH, 8'h00, 8'h00, 0);
    ex(0, S_PCL8, 8'h00, "fetch_pcl8_0");
    ex(1, S_ABL, 8'hFD, "fetch_abl"); ex(1, S_PCL, 8'hFD, "fetch_pcl");
    nxt; drive(0, 1, AB_ABS0, 8'hF0, 8'h20, 1);
    ex(1, S_ABL, 8'h10, "abs_idx_abl"); ex(1, S_CO, 8'h01, "abs_idx_co");
    ex(1, S_PCL, 8'hFE, "abs_idx_pcl");
    nxt; drive(0, 1, AB_ABS0, 8'hF0, 8'h20, 0);
    ex(1, S_ABL, 8'hF0, "abs_noidx_abl"); ex(1, S_CO, 8'h00, "abs_noidx_co");
    nxt; drive(0, 1, AB_ZPXY, 8'hF0, 8'h20, 1);
    ex(1, S_ABL, 8'h10, "zp_abl"); ex(1, S_CO, 8'h00, "zp_co");
    nxt; drive(0, 1, AB_ABS0, 8'hFF, 8'h00, 0);
    ex(1, S_ABL, 8'hFF, "abs_ff_abl");
    nxt; drive(0, 1, AB_FETCH, 8'h00, 8'h00, 0);
    ex(0, S_PCL8, 8'h01, "wrap_pcl8");
    ex(1, S_ABL, 8'h00, "wrap_abl"); ex(1, S_PCL, 8'h00, "wrap_pcl");
    nxt; drive(0, 1, AB_TXS, 8'h00, 8'h00, 0);
    ex(1, S_S, 8'h00, "txs0_s"); ex(1, S_ABL, 8'h01, "txs0_abl");
    nxt; drive(0, 1, AB_PHA, 8'h00, 8'h00, 0);
    ex(0, S_OE, 8'h00, "pha_oe");
    ex(1, S_ABL, 8'h00, "pha_abl"); ex(1, S_S, 8'hFF, "pha_s");
    nxt; drive(0, 1, AB_PLA, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'h00, "pla_abl"); ex(1, S_S, 8'h00, "pla_s");
    nxt; drive(0, 1, AB_TXS, 8'h00, 8'h42, 0);
    ex(1, S_S, 8'h42, "txs42_s"); ex(1, S_ABL, 8'h01, "txs42_abl");
    ex(1, S_PCL, 8'h01, "txs42_pcl");
    nxt; drive(0, 0, AB_PHA, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'h01, "hold1_abl"); ex(1, S_S, 8'h42, "hold1_s");
    ex(1, S_PCL, 8'h01, "hold1_pcl");
    nxt; drive(0, 1, AB_ABS0, 8'hF7, 8'h00, 0);
    ex(1, S_ABL, 8'hF7, "absf7_abl"); ex(1, S_PCL, 8'h02, "absf7_pcl");
    nxt; drive(0, 1, AB_FETCH, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'hF8, "f8_abl"); ex(1, S_PCL, 8'hF8, "f8_pcl");
    nxt; drive(0, 1, AB_BRA0, 8'h00, 8'h10, 0);
    ex(1, S_ABL, 8'h08, "bra_abl"); ex(1, S_CO, 8'h01, "bra_co");
    ex(1, S_PCL, 8'hF8, "bra_pcl");
    nxt; drive(0, 0, AB_ABS0, 8'hFF, 8'hFF, 1);
    ex(1, S_ABL, 8'h08, "hold2_abl"); ex(1, S_CO, 8'h01, "hold2_co");
    ex(1, S_PCL, 8'hF8, "hold2_pcl"); ex(1, S_S, 8'h42, "hold2_s");
    nxt; drive(0, 1, AB_JSR1, 8'h5A, 8'h00, 0);
    ex(0, S_OE, 8'h01, "jsr1_oe");
    ex(1, S_ABL, 8'hF8, "jsr1_abl"); ex(1, S_CO, 8'h00, "jsr1_co");
    nxt; drive(0, 1, AB_JMP0, 8'hFF, 8'h00, 0);
    ex(1, S_ABL, 8'h5A, "jmp_abl");
    nxt; drive(0, 1, AB_RTS1, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'h00, "rts1_abl"); ex(1, S_CO, 8'h01, "rts1_co");
    nxt; drive(0, 1, AB_RMW, 8'h33, 8'h00, 0);
    ex(1, S_ABL, 8'h00, "rmw_abl"); ex(1, S_CO, 8'h01, "rmw_co");
    nxt; drive(0, 1, AB_BRK2, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'hFE, "brk2_abl"); ex(1, S_CO, 8'h00, "brk2_co");
    nxt; drive(0, 1, AB_NMI, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'hFA, "nmi_abl");
    nxt; drive(0, 1, AB_RST, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'hFC, "rstop_abl");
    nxt; drive(0, 1, AB_BRK, 8'h00, 8'h00, 0);
    ex(1, S_ABL, 8'h42, "brk_abl"); ex(1, S_S, 8'h41, "brk_s");
    ex(1, S_PCL, 8'hFD, "brk_pcl");
    nxt; drive(1, 0, AB_BRA0, 8'h00, 8'h10, 0);
    ex(1, S_ABL, 8'hFC, "midrst_abl"); ex(1, S_S, 8'hFD, "midrst_s");
    ex(1, S_CO, 8'h00, "midrst_co"); ex(1, S_PCL, 8'hFC, "midrst_pcl");
    nxt; drive(0, 1, AB_FETCH, 8'h00, 8'h00, 0);
    done = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
